// File: rtl/inst_u_enc_writer_pkg.sv
// Shared definitions for the U-type instruction encoder/writer: opcodes,
// U-type field positions, FSM state type and an opcode-select helper.
package inst_u_enc_writer_pkg;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // U-type field positions, matching the decoder side
    localparam int U_OPC_LSB = 0;
    localparam int U_RD_LSB  = 7;
    localparam int U_IMM_LSB = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } wr_state_e;

    // Map the one-bit opcode select onto the 7-bit major opcode
    function automatic logic [6:0] u_opcode(input logic op);
        logic [6:0] opc;
        if (op) begin
            opc = OPC_AUIPC;
        end else begin
            opc = OPC_LUI;
        end
        return opc;
    endfunction

endpackage

// File: rtl/inst_u_pack.sv
// Combinational packer: {op, rd, imm} -> 32-bit U-type instruction word.
module inst_u_pack
    import inst_u_enc_writer_pkg::*;
(
    input  logic        op_i,
    input  logic [4:0]  rd_i,
    input  logic [19:0] imm_i,
    output logic [31:0] word_o
);

    // Place each field at its U-type bit position; rd=0 is encoded as given
    always_comb begin
        word_o                        = 32'h0000_0000;
        word_o[U_IMM_LSB +: 20]       = imm_i;
        word_o[U_RD_LSB  +: 5]        = rd_i;
        word_o[U_OPC_LSB +: 7]        = u_opcode(op_i);
    end

endmodule

// File: rtl/inst_u_enc_writer.sv
// U-type instruction encoder/writer: accepts {op, rd, imm} over valid/ready,
// encodes them and streams the words into instruction memory at sequential
// byte addresses through a single registered output stage.
module inst_u_enc_writer
    import inst_u_enc_writer_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          DEPTH     = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_op,
    input  logic [4:0]              in_rd,
    input  logic [19:0]             in_imm,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [$clog2(DEPTH):0]  wr_count,
    output logic                    done
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    wr_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;

    logic [31:0]        packed_s;
    logic               accept_s;
    logic               drain_s;

    inst_u_pack u_pack (
        .op_i   (in_op),
        .rd_i   (in_rd),
        .imm_i  (in_imm),
        .word_o (packed_s)
    );

    // Output stage may be refilled in the same cycle it drains
    assign in_ready = (state_q == ST_RUN) && (!we_q || mem_ready);
    assign accept_s = in_valid && in_ready;
    assign drain_s  = we_q && mem_ready;

    // Next-state logic for FSM, output stage, address and word counter
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        count_d = count_q;
        done_d  = done_q;

        // A completed write frees the stage and advances the address (wraps)
        if (drain_s) begin
            addr_d = addr_q + ADDR_W'(4);
            we_d   = 1'b0;
        end else begin
            addr_d = addr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = BASE_A;
                    count_d = {CNT_W{1'b0}};
                    done_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                done_d = 1'b0;
                if (accept_s) begin
                    we_d    = 1'b1;
                    wdata_d = packed_s;
                    count_d = count_q + CNT_W'(1);
                    if (count_q + CNT_W'(1) == CNT_W'(DEPTH)) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FULL: begin
                // Run is only complete once the last word has left the stage
                done_d = !we_d;
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = BASE_A;
                    count_d = {CNT_W{1'b0}};
                    done_d  = 1'b0;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                we_d    = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any pending word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_A;
            wdata_q <= 32'h0000_0000;
            we_q    <= 1'b0;
            count_q <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wr_count  = count_q;
    assign done      = done_q;

endmodule
